ctrl_decode_pipe: RTL and testbench

- Registered ID-stage control decoder for the pipelined MIPS core; successor to the combinational control decoder.
- Decodes one 32-bit instruction per cycle into the ID/EX control bundle, keeping the existing PCSrc, RegDst, MemToReg and ALUFun encodings.
- Adds NUM_IRQ maskable interrupt channels with sticky pending bits and fixed priority, stall/flush handshake, an explicit illegal-op flag, and fully defined (latch-free) outputs.

---
 rtl/ctrl_pkg.sv | 98 +++++++++
 rtl/irq_arbiter.sv | 47 ++++
 rtl/ctrl_decode_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/funct constants, control encodings and the ID/EX control bundle
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGEZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_BR   = 3'b001;
    localparam logic [2:0] PC_JT   = 3'b010;
    localparam logic [2:0] PC_JR   = 3'b011;
    localparam logic [2:0] PC_IRQ  = 3'b100;
    localparam logic [2:0] PC_XADR = 3'b101;

    localparam logic [1:0] RD_RD = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;
    localparam logic [1:0] RD_XP = 2'b11;

    localparam logic [1:0] MR_ALU = 2'b00;
    localparam logic [1:0] MR_RAM = 2'b01;
    localparam logic [1:0] MR_PC4 = 2'b10;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b000001;
    localparam logic [5:0] ALU_AND  = 6'b011000;
    localparam logic [5:0] ALU_OR   = 6'b011110;
    localparam logic [5:0] ALU_XOR  = 6'b010110;
    localparam logic [5:0] ALU_NOR  = 6'b010001;
    localparam logic [5:0] ALU_SLT  = 6'b110101;
    localparam logic [5:0] ALU_SLL  = 6'b100000;
    localparam logic [5:0] ALU_SRL  = 6'b100001;
    localparam logic [5:0] ALU_SRA  = 6'b100011;
    localparam logic [5:0] ALU_BEQ  = 6'b110011;
    localparam logic [5:0] ALU_BNE  = 6'b110001;
    localparam logic [5:0] ALU_BLEZ = 6'b111101;
    localparam logic [5:0] ALU_BGTZ = 6'b111111;
    localparam logic [5:0] ALU_BGEZ = 6'b111001;

    typedef struct packed {
        logic [2:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [5:0] alufun;
        logic       regwr;
        logic       alusrc1;
        logic       alusrc2;
        logic       sign;
        logic       memwr;
        logic       memrd;
        logic       extop;
        logic       luop;
        logic       ctrl_valid;
        logic       irq_taken;
        logic       illop;
    } ctrl_t;

    // Interrupt entry and illegal-op trap share the same link-to-$xp shape.
    function automatic ctrl_t trap_bundle(input logic [2:0] pcsrc);
        ctrl_t c;
        c            = '0;
        c.pcsrc      = pcsrc;
        c.regdst     = RD_XP;
        c.regwr      = 1'b1;
        c.memtoreg   = MR_PC4;
        c.ctrl_valid = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - sticky pending/mask registers with fixed lowest-index-first pick
module irq_arbiter #(
    parameter int NUM_IRQ = 4,
    parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    input  logic               en_i,
    output logic               take_o,
    output logic [IRQ_W-1:0]   id_o
);

    logic [NUM_IRQ-1:0] pend_d, pend_q;
    logic [NUM_IRQ-1:0] mask_d, mask_q;
    logic [NUM_IRQ-1:0] clr;
    logic [IRQ_W-1:0]   win;

    // Pick the lowest pending index; new requests override this cycle's clear.
    always_comb begin
        win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win = IRQ_W'(i);
            end
        end
        take_o = en_i & (|pend_q);
        id_o   = win;
        clr    = take_o ? (NUM_IRQ'(1) << win) : '0;
        pend_d = (pend_q & ~clr) | (irq_i & mask_q);
        mask_d = mask_we_i ? mask_wdata_i : mask_q;
    end

    // Pending and mask state; mask resets to all channels enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            mask_q <= '1;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - registered ID-stage control decoder with interrupt entry
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    input  logic               kernel_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mask_we_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    output logic [2:0]         pcsrc_o,
    output logic [1:0]         regdst_o,
    output logic [1:0]         memtoreg_o,
    output logic [5:0]         alufun_o,
    output logic               regwr_o,
    output logic               alusrc1_o,
    output logic               alusrc2_o,
    output logic               sign_o,
    output logic               memwr_o,
    output logic               memrd_o,
    output logic               extop_o,
    output logic               luop_o,
    output logic               ctrl_valid_o,
    output logic               irq_taken_o,
    output logic [IRQ_W-1:0]   irq_id_o,
    output logic               illop_o
);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             instr_unused;
    ctrl_t            dec;
    ctrl_t            ctrl_d, ctrl_q;
    logic [IRQ_W-1:0] irq_id_d, irq_id_q;
    logic             irq_en;
    logic             irq_take;
    logic [IRQ_W-1:0] irq_win;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];
    // Register and immediate fields are consumed downstream, not by the decoder.
    assign instr_unused = ^instr_i[25:6];

    assign irq_en = ~kernel_i & instr_valid_i & ~stall_i & ~flush_i;

    irq_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .IRQ_W   (IRQ_W)
    ) u_irq_arbiter (
        .clk          (clk),
        .reset        (reset),
        .irq_i        (irq_i),
        .mask_we_i    (mask_we_i),
        .mask_wdata_i (mask_wdata_i),
        .en_i         (irq_en),
        .take_o       (irq_take),
        .id_o         (irq_win)
    );

    // Instruction decode; every field starts at 0 and unknown encodings trap.
    always_comb begin
        dec            = '0;
        dec.ctrl_valid = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec.regdst = RD_RD;
                dec.regwr  = 1'b1;
                case (funct)
                    FN_ADD:  begin dec.alufun = ALU_ADD; dec.sign = 1'b1; end
                    FN_ADDU: dec.alufun = ALU_ADD;
                    FN_SUB:  begin dec.alufun = ALU_SUB; dec.sign = 1'b1; end
                    FN_SUBU: dec.alufun = ALU_SUB;
                    FN_AND:  dec.alufun = ALU_AND;
                    FN_OR:   dec.alufun = ALU_OR;
                    FN_XOR:  dec.alufun = ALU_XOR;
                    FN_NOR:  dec.alufun = ALU_NOR;
                    FN_SLT:  begin dec.alufun = ALU_SLT; dec.sign = 1'b1; end
                    FN_SLL:  begin dec.alufun = ALU_SLL; dec.alusrc1 = 1'b1; end
                    FN_SRL:  begin dec.alufun = ALU_SRL; dec.alusrc1 = 1'b1; end
                    FN_SRA:  begin dec.alufun = ALU_SRA; dec.alusrc1 = 1'b1; end
                    FN_JR: begin
                        dec.pcsrc = PC_JR;
                        dec.regwr = 1'b0;
                    end
                    FN_JALR: begin
                        dec.pcsrc    = PC_JR;
                        dec.regdst   = RD_RA;
                        dec.memtoreg = MR_PC4;
                    end
                    default: begin
                        dec       = trap_bundle(PC_XADR);
                        dec.illop = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI, OP_LW: begin
                dec.regdst  = RD_RT;
                dec.regwr   = 1'b1;
                dec.alusrc2 = 1'b1;
                case (opcode)
                    OP_ADDI:  begin dec.sign = 1'b1; dec.extop = 1'b1; end
                    OP_ANDI:  dec.alufun = ALU_AND;
                    OP_SLTI:  begin dec.alufun = ALU_SLT; dec.sign = 1'b1; dec.extop = 1'b1; end
                    OP_SLTIU: dec.alufun = ALU_SLT;
                    OP_LUI:   dec.luop = 1'b1;
                    OP_LW: begin
                        dec.memrd    = 1'b1;
                        dec.memtoreg = MR_RAM;
                        dec.sign     = 1'b1;
                        dec.extop    = 1'b1;
                    end
                    default: dec.alufun = ALU_ADD;
                endcase
            end
            OP_SW: begin
                dec.memwr   = 1'b1;
                dec.alusrc2 = 1'b1;
                dec.sign    = 1'b1;
                dec.extop   = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ: begin
                dec.pcsrc = PC_BR;
                dec.sign  = 1'b1;
                dec.extop = 1'b1;
                case (opcode)
                    OP_BEQ:  dec.alufun = ALU_BEQ;
                    OP_BNE:  dec.alufun = ALU_BNE;
                    OP_BLEZ: dec.alufun = ALU_BLEZ;
                    OP_BGTZ: dec.alufun = ALU_BGTZ;
                    default: dec.alufun = ALU_BGEZ;
                endcase
            end
            OP_J: dec.pcsrc = PC_JT;
            OP_JAL: begin
                dec.pcsrc    = PC_JT;
                dec.regdst   = RD_RA;
                dec.regwr    = 1'b1;
                dec.memtoreg = MR_PC4;
            end
            default: begin
                dec       = trap_bundle(PC_XADR);
                dec.illop = 1'b1;
            end
        endcase
    end

    // Next ID/EX bundle: flush beats stall, stall holds, interrupt beats decode.
    always_comb begin
        ctrl_d   = ctrl_q;
        irq_id_d = irq_id_q;
        if (flush_i) begin
            ctrl_d   = '0;
            irq_id_d = '0;
        end else if (stall_i) begin
            ctrl_d   = ctrl_q;
            irq_id_d = irq_id_q;
        end else if (irq_take) begin
            ctrl_d           = trap_bundle(PC_IRQ);
            ctrl_d.irq_taken = 1'b1;
            irq_id_d         = irq_win;
        end else if (instr_valid_i) begin
            ctrl_d   = dec;
            irq_id_d = '0;
        end else begin
            ctrl_d   = '0;
            irq_id_d = '0;
        end
    end

    // ID/EX control register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            irq_id_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign pcsrc_o      = ctrl_q.pcsrc;
    assign regdst_o     = ctrl_q.regdst;
    assign memtoreg_o   = ctrl_q.memtoreg;
    assign alufun_o     = ctrl_q.alufun;
    assign regwr_o      = ctrl_q.regwr;
    assign alusrc1_o    = ctrl_q.alusrc1;
    assign alusrc2_o    = ctrl_q.alusrc2;
    assign sign_o       = ctrl_q.sign;
    assign memwr_o      = ctrl_q.memwr;
    assign memrd_o      = ctrl_q.memrd;
    assign extop_o      = ctrl_q.extop;
    assign luop_o       = ctrl_q.luop;
    assign ctrl_valid_o = ctrl_q.ctrl_valid;
    assign irq_taken_o  = ctrl_q.irq_taken;
    assign irq_id_o     = irq_id_q;
    assign illop_o      = ctrl_q.illop;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - directed scoreboard bench for ctrl_decode_pipe
module tb_ctrl_decode_pipe;

    typedef struct packed {
        logic [2:0] pcsrc;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [5:0] alufun;
        logic       regwr;
        logic       alusrc1;
        logic       alusrc2;
        logic       sign;
        logic       memwr;
        logic       memrd;
        logic       extop;
        logic       luop;
        logic       ctrl_valid;
        logic       irq_taken;
        logic [1:0] irq_id;
        logic       illop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        valid;
    logic        kernel;
    logic        stall;
    logic        flush;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [2:0]  pcsrc;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    logic [5:0]  alufun;
    logic        regwr, alusrc1, alusrc2, sign, memwr, memrd, extop, luop;
    logic        ctrl_valid, irq_taken, illop;
    logic [1:0]  irq_id;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    ctrl_decode_pipe #(.NUM_IRQ(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_i       (instr),
        .instr_valid_i (valid),
        .kernel_i      (kernel),
        .stall_i       (stall),
        .flush_i       (flush),
        .irq_i         (irq),
        .mask_we_i     (mask_we),
        .mask_wdata_i  (mask_wdata),
        .pcsrc_o       (pcsrc),
        .regdst_o      (regdst),
        .memtoreg_o    (memtoreg),
        .alufun_o      (alufun),
        .regwr_o       (regwr),
        .alusrc1_o     (alusrc1),
        .alusrc2_o     (alusrc2),
        .sign_o        (sign),
        .memwr_o       (memwr),
        .memrd_o       (memrd),
        .extop_o       (extop),
        .luop_o        (luop),
        .ctrl_valid_o  (ctrl_valid),
        .irq_taken_o   (irq_taken),
        .irq_id_o      (irq_id),
        .illop_o       (illop)
    );

    always #5 clk = ~clk;

    function automatic exp_t e_zero();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t e_r(input logic [5:0] fun, input logic sgn, input logic src1);
        exp_t e;
        e            = '0;
        e.alufun     = fun;
        e.sign       = sgn;
        e.alusrc1    = src1;
        e.regwr      = 1'b1;
        e.ctrl_valid = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_irq(input logic [1:0] id);
        exp_t e;
        e            = '0;
        e.pcsrc      = 3'b100;
        e.regdst     = 2'b11;
        e.regwr      = 1'b1;
        e.memtoreg   = 2'b10;
        e.irq_taken  = 1'b1;
        e.irq_id     = id;
        e.ctrl_valid = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_ill();
        exp_t e;
        e            = '0;
        e.pcsrc      = 3'b101;
        e.regdst     = 2'b11;
        e.regwr      = 1'b1;
        e.memtoreg   = 2'b10;
        e.illop      = 1'b1;
        e.ctrl_valid = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_lw();
        exp_t e;
        e            = '0;
        e.regdst     = 2'b01;
        e.regwr      = 1'b1;
        e.alusrc2    = 1'b1;
        e.memrd      = 1'b1;
        e.memtoreg   = 2'b01;
        e.sign       = 1'b1;
        e.extop      = 1'b1;
        e.ctrl_valid = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_addi();
        exp_t e;
        e            = '0;
        e.regdst     = 2'b01;
        e.regwr      = 1'b1;
        e.alusrc2    = 1'b1;
        e.sign       = 1'b1;
        e.extop      = 1'b1;
        e.ctrl_valid = 1'b1;
        return e;
    endfunction

    // Push the expectation for the currently driven inputs, clock once, then pop and compare.
    task automatic step(input exp_t e, input string tag);
        exp_t want;
        exp_t got;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = {pcsrc, regdst, memtoreg, alufun, regwr, alusrc1, alusrc2, sign,
                memwr, memrd, extop, luop, ctrl_valid, irq_taken, irq_id, illop};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %07h expected %07h", t, got, want);
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; instr = 32'h0; valid = 1'b0; kernel = 1'b0; stall = 1'b0;
        flush = 1'b0; irq = 4'b0; mask_we = 1'b0; mask_wdata = 4'b0;
        @(negedge clk);
        step(e_zero(), "reset_a");
        step(e_zero(), "reset_b");
        reset = 1'b0;

        valid = 1'b1;
        instr = 32'h00851020; step(e_r(6'b000000, 1'b1, 1'b0), "add");
        instr = 32'h0080F809;
        e = '0; e.pcsrc = 3'b011; e.regdst = 2'b10; e.regwr = 1'b1; e.memtoreg = 2'b10; e.ctrl_valid = 1'b1;
        step(e, "jalr");
        instr = 32'h00851022; step(e_r(6'b000001, 1'b1, 1'b0), "sub");
        instr = 32'h00041080; step(e_r(6'b100000, 1'b0, 1'b1), "sll");
        instr = 32'h10850003;
        e = '0; e.pcsrc = 3'b001; e.alufun = 6'b110011; e.sign = 1'b1; e.extop = 1'b1; e.ctrl_valid = 1'b1;
        step(e, "beq");
        instr = 32'h0C000010;
        e = '0; e.pcsrc = 3'b010; e.regdst = 2'b10; e.regwr = 1'b1; e.memtoreg = 2'b10; e.ctrl_valid = 1'b1;
        step(e, "jal");
        instr = 32'hAC450004;
        e = '0; e.memwr = 1'b1; e.alusrc2 = 1'b1; e.sign = 1'b1; e.extop = 1'b1; e.ctrl_valid = 1'b1;
        step(e, "sw");
        instr = 32'h3C021234;
        e = '0; e.regdst = 2'b01; e.regwr = 1'b1; e.alusrc2 = 1'b1; e.luop = 1'b1; e.ctrl_valid = 1'b1;
        step(e, "lui");
        instr = 32'h00851020; valid = 1'b0; step(e_zero(), "bubble");
        valid = 1'b1;

        instr = 32'h8C450004; irq = 4'b1010; step(e_lw(), "irq_latch");
        irq = 4'b0000; step(e_irq(2'd1), "irq_take1");
        step(e_irq(2'd3), "irq_take3");
        step(e_lw(), "irq_drained");

        instr = 32'h00851020; kernel = 1'b1; irq = 4'b0001; step(e_r(6'b000000, 1'b1, 1'b0), "kern_0");
        irq = 4'b0000;
        for (int i = 1; i < 5; i++) begin
            step(e_r(6'b000000, 1'b1, 1'b0), $sformatf("kern_%0d", i));
        end
        kernel = 1'b0; step(e_irq(2'd0), "kern_exit_take");

        instr = 32'hFC000000; mask_we = 1'b1; mask_wdata = 4'b0000; step(e_ill(), "illop");
        mask_we = 1'b0; irq = 4'b0001; step(e_ill(), "masked_a");
        step(e_ill(), "masked_b");
        irq = 4'b0000; mask_we = 1'b1; mask_wdata = 4'b1111; step(e_ill(), "unmask");
        mask_we = 1'b0; irq = 4'b0100; step(e_ill(), "ill_pend");
        irq = 4'b0000; step(e_irq(2'd2), "irq_over_illop");

        instr = 32'h20A50001; stall = 1'b1; flush = 1'b1; step(e_zero(), "flush_stall");
        stall = 1'b0; flush = 1'b0; step(e_addi(), "addi");
        instr = 32'h00851026; stall = 1'b1; irq = 4'b0010; step(e_addi(), "stall_hold_a");
        irq = 4'b0000; step(e_addi(), "stall_hold_b");
        instr = 32'h00851020; stall = 1'b0; flush = 1'b1; step(e_zero(), "flush_no_take");
        flush = 1'b0; step(e_irq(2'd1), "take_after_stall");
        step(e_r(6'b000000, 1'b1, 1'b0), "add_after_take");

        irq = 4'b0001; step(e_r(6'b000000, 1'b1, 1'b0), "pre_reset");
        irq = 4'b0000; reset = 1'b1; step(e_zero(), "mid_reset");
        reset = 1'b0; step(e_r(6'b000000, 1'b1, 1'b0), "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
